// File: rtl/wb_stage_regfile_if.sv
// MEM/WB slot bundle plus the ID/EX read ports served by the writeback stage.
// master: upstream pipeline (drives the slot and read addresses)
// slave : wb_stage_regfile (returns read data, forwarding value, retire trace)
interface wb_stage_regfile_if #(
   parameter int XLEN = 32
);
   logic            wb_valid;
   logic            wb_stall;
   logic            wb_reg_we;
   logic [4:0]      wb_rd_addr;
   logic            wb_sel_mem;
   logic [XLEN-1:0] wb_alu_data;
   logic            wb_mem_read;
   logic [XLEN-1:0] wb_mem_rdata;
   logic [2:0]      wb_funct3;
   logic            wb_csr_we;
   logic [11:0]     wb_csr_addr;
   logic [XLEN-1:0] wb_csr_wdata;
   logic [XLEN-1:0] wb_pc;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [11:0]     csr_raddr;
   logic [XLEN-1:0] csr_rdata;
   logic [XLEN-1:0] wb_result;
   logic [XLEN-1:0] retire_pc;

   modport master (
      output wb_valid, wb_stall, wb_reg_we, wb_rd_addr, wb_sel_mem, wb_alu_data,
             wb_mem_read, wb_mem_rdata, wb_funct3, wb_csr_we, wb_csr_addr,
             wb_csr_wdata, wb_pc, rs1_addr, rs2_addr, csr_raddr,
      input  rs1_data, rs2_data, csr_rdata, wb_result, retire_pc
   );

   modport slave (
      input  wb_valid, wb_stall, wb_reg_we, wb_rd_addr, wb_sel_mem, wb_alu_data,
             wb_mem_read, wb_mem_rdata, wb_funct3, wb_csr_we, wb_csr_addr,
             wb_csr_wdata, wb_pc, rs1_addr, rs2_addr, csr_raddr,
      output rs1_data, rs2_data, csr_rdata, wb_result, retire_pc
   );
endinterface

// File: rtl/wb_stage_regfile.sv
// Writeback stage of the 5-stage RV32I core.
// - Selects the writeback value (ALU result or extracted/extended load data).
// - Owns the 32x32 integer register file (2 combinational read ports with
//   same-cycle write bypass) and a small machine CSR bank with 64-bit
//   mcycle/minstret counters.
// - Exports retire_pc, the PC of the last committed instruction.
// Ports:
//   clk, rst  : core clock, asynchronous active-high reset
//   bus.slave : MEM/WB slot inputs, rs1/rs2/csr read ports, wb_result, retire_pc
module wb_stage_regfile #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter logic [31:0] MTVEC_RST = 32'h0
) (
   input logic                 clk,
   input logic                 rst,
   wb_stage_regfile_if.slave   bus
);
   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
   localparam logic [11:0] CSR_MINSTR   = 12'hB02;
   localparam logic [11:0] CSR_MINSTRH  = 12'hB82;

   logic            commit;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] result;
   logic [XLEN-1:0] regs [0:31];

   logic [XLEN-1:0] mstatus, mie, mtvec, mepc, mcause;
   logic [2*XLEN-1:0] mcycle, minstret;
   logic [2*XLEN-1:0] mcycle_inc, minstret_inc;
   logic [2*XLEN-1:0] mcycle_nxt, minstret_nxt;
   logic            csr_wr;
   logic [XLEN-1:0] csr_wval;
   logic            csr_mapped;
   logic [XLEN-1:0] csr_stored;

   assign commit = bus.wb_valid & ~bus.wb_stall;
   assign csr_wr = commit & bus.wb_csr_we;

   // ---------------- load extract ----------------
   logic [1:0]  off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign off     = bus.wb_alu_data[1:0];
   assign ld_byte = bus.wb_mem_rdata[{off, 3'b000} +: 8];
   assign ld_half = bus.wb_mem_rdata[{off[1], 4'b0000} +: 16];

   always_comb begin
      load_data = bus.wb_mem_rdata;
      case (bus.wb_funct3)
         3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
         default: load_data = bus.wb_mem_rdata;
      endcase
   end

   assign result        = (bus.wb_sel_mem & bus.wb_mem_read) ? load_data : bus.wb_alu_data;
   assign bus.wb_result = result;

   // ---------------- integer register file ----------------
   logic rf_wr;
   assign rf_wr = commit & bus.wb_reg_we & (bus.wb_rd_addr != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (rf_wr) begin
         regs[bus.wb_rd_addr] <= result;
      end
   end

   // x0 is never written, but force zero anyway so reads never depend on storage
   always_comb begin
      if (bus.rs1_addr == 5'd0)                     bus.rs1_data = '0;
      else if (rf_wr && bus.wb_rd_addr == bus.rs1_addr) bus.rs1_data = result;
      else                                          bus.rs1_data = regs[bus.rs1_addr];
   end

   always_comb begin
      if (bus.rs2_addr == 5'd0)                     bus.rs2_data = '0;
      else if (rf_wr && bus.wb_rd_addr == bus.rs2_addr) bus.rs2_data = result;
      else                                          bus.rs2_data = regs[bus.rs2_addr];
   end

   // ---------------- CSR bank ----------------
   // Trap vector and return PC are word aligned; low bits are hardwired to 0,
   // so the bypassed value is masked the same way as the stored one.
   always_comb begin
      csr_wval = bus.wb_csr_wdata;
      if (bus.wb_csr_addr == CSR_MTVEC || bus.wb_csr_addr == CSR_MEPC)
         csr_wval[1:0] = 2'b00;
   end

   assign mcycle_inc   = mcycle + 1'b1;
   assign minstret_inc = minstret + 1'b1;

   // Writing a counter half replaces that half's increment. Writing the low
   // half also drops the carry into the high half (high half holds).
   always_comb begin
      mcycle_nxt   = mcycle_inc;
      minstret_nxt = commit ? minstret_inc : minstret;
      if (csr_wr) begin
         case (bus.wb_csr_addr)
            CSR_MCYCLE:  mcycle_nxt   = {mcycle[2*XLEN-1:XLEN], csr_wval};
            CSR_MCYCLEH: mcycle_nxt   = {csr_wval, mcycle_inc[XLEN-1:0]};
            CSR_MINSTR:  minstret_nxt = {minstret[2*XLEN-1:XLEN], csr_wval};
            CSR_MINSTRH: minstret_nxt = {csr_wval, minstret_inc[XLEN-1:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatus  <= '0;
         mie      <= '0;
         mtvec    <= {MTVEC_RST[XLEN-1:2], 2'b00};
         mepc     <= '0;
         mcause   <= '0;
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         mcycle   <= mcycle_nxt;
         minstret <= minstret_nxt;
         if (csr_wr) begin
            case (bus.wb_csr_addr)
               CSR_MSTATUS: mstatus <= csr_wval;
               CSR_MIE:     mie     <= csr_wval;
               CSR_MTVEC:   mtvec   <= csr_wval;
               CSR_MEPC:    mepc    <= csr_wval;
               CSR_MCAUSE:  mcause  <= csr_wval;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      csr_mapped = 1'b1;
      csr_stored = '0;
      case (bus.csr_raddr)
         CSR_MSTATUS: csr_stored = mstatus;
         CSR_MIE:     csr_stored = mie;
         CSR_MTVEC:   csr_stored = mtvec;
         CSR_MEPC:    csr_stored = mepc;
         CSR_MCAUSE:  csr_stored = mcause;
         CSR_MCYCLE:  csr_stored = mcycle[XLEN-1:0];
         CSR_MCYCLEH: csr_stored = mcycle[2*XLEN-1:XLEN];
         CSR_MINSTR:  csr_stored = minstret[XLEN-1:0];
         CSR_MINSTRH: csr_stored = minstret[2*XLEN-1:XLEN];
         default:     csr_mapped = 1'b0;
      endcase
   end

   // Bypass only for mapped addresses so an unmapped write can never leak out.
   always_comb begin
      if (csr_mapped && csr_wr && bus.wb_csr_addr == bus.csr_raddr) bus.csr_rdata = csr_wval;
      else                                                         bus.csr_rdata = csr_stored;
   end

   // ---------------- retire trace ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         bus.retire_pc <= RESET_PC;
      else if (commit) bus.retire_pc <= bus.wb_pc;
   end
endmodule

// File: tb/tb_wb_stage_regfile.sv
module tb_wb_stage_regfile;
   localparam logic [31:0] RPC  = 32'h0000_0200;
   localparam logic [31:0] MTVR = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   logic [31:0] m0, i0, i1, rp0;

   always #5 clk = ~clk;

   wb_stage_regfile_if #(.XLEN(32)) bus();

   wb_stage_regfile #(.XLEN(32), .RESET_PC(RPC), .MTVEC_RST(MTVR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      bus.wb_valid = 0; bus.wb_stall = 0; bus.wb_reg_we = 0; bus.wb_rd_addr = 0;
      bus.wb_sel_mem = 0; bus.wb_alu_data = 0; bus.wb_mem_read = 0; bus.wb_mem_rdata = 0;
      bus.wb_funct3 = 0; bus.wb_csr_we = 0; bus.wb_csr_addr = 0; bus.wb_csr_wdata = 0;
      bus.wb_pc = 0;
   endtask

   // committed load into rd
   task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] word, input logic [31:0] pc);
      idle();
      bus.wb_valid = 1; bus.wb_reg_we = 1; bus.wb_rd_addr = rd; bus.wb_sel_mem = 1;
      bus.wb_mem_read = 1; bus.wb_funct3 = f3; bus.wb_alu_data = addr;
      bus.wb_mem_rdata = word; bus.wb_pc = pc;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      idle();
      bus.wb_valid = 1; bus.wb_csr_we = 1; bus.wb_csr_addr = a; bus.wb_csr_wdata = d;
      bus.wb_pc = 32'h0000_0500;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1; idle();
      bus.rs1_addr = 5; bus.rs2_addr = 31; bus.csr_raddr = 12'h305;
      tick(); tick();
      chk("rst_x5", bus.rs1_data, 32'h0);
      chk("rst_x31", bus.rs2_data, 32'h0);
      chk("rst_mtvec", bus.csr_rdata, MTVR);
      chk("rst_pc", bus.retire_pc, RPC);
      bus.csr_raddr = 12'hB00; #1 chk("rst_mcycle", bus.csr_rdata, 32'h0);
      bus.csr_raddr = 12'hB02; #1 chk("rst_minstret", bus.csr_rdata, 32'h0);
      rst = 0;

      // LB off=3 -> sign-extended 0x80, bypassed same cycle
      load(5, 3'b000, 32'h0000_1003, 32'h80FF_1234, 32'h0000_1000);
      bus.rs1_addr = 5; #1;
      chk("lb_result", bus.wb_result, 32'hFFFF_FF80);
      chk("lb_bypass", bus.rs1_data, 32'hFFFF_FF80);
      tick(); idle(); #1;
      chk("lb_stored", bus.rs1_data, 32'hFFFF_FF80);
      chk("retire_lb", bus.retire_pc, 32'h0000_1000);

      // LBU same
      load(6, 3'b100, 32'h0000_1003, 32'h80FF_1234, 32'h0000_1004); #1;
      chk("lbu_result", bus.wb_result, 32'h0000_0080);
      // LHU off=2
      load(6, 3'b101, 32'h0000_1002, 32'h80FF_1234, 32'h0000_1008); #1;
      chk("lhu_result", bus.wb_result, 32'h0000_80FF);
      // LH off=2 sign-extends
      load(6, 3'b001, 32'h0000_1002, 32'h80FF_1234, 32'h0000_100C); #1;
      chk("lh_hi", bus.wb_result, 32'hFFFF_80FF);
      // LH off=0 positive
      load(6, 3'b001, 32'h0000_1000, 32'h80FF_1234, 32'h0000_1010); #1;
      chk("lh_lo", bus.wb_result, 32'h0000_1234);
      // LB off=1 positive byte
      load(6, 3'b000, 32'h0000_1001, 32'h80FF_1234, 32'h0000_1014); #1;
      chk("lb_off1", bus.wb_result, 32'h0000_0012);
      // LW ignores offset; funct3 011 passes full word
      load(6, 3'b010, 32'h0000_1003, 32'h80FF_1234, 32'h0000_1018); #1;
      chk("lw_result", bus.wb_result, 32'h80FF_1234);
      load(6, 3'b011, 32'h0000_1001, 32'hCAFE_BABE, 32'h0000_101C); #1;
      chk("f3_011", bus.wb_result, 32'hCAFE_BABE);
      // sel_mem without mem_read -> ALU value
      bus.wb_mem_read = 0; #1;
      chk("sel_alu", bus.wb_result, 32'h0000_1001);
      bus.wb_mem_read = 1;
      tick(); idle(); bus.rs2_addr = 6; #1;
      chk("x6_stored", bus.rs2_data, 32'hCAFE_BABE);

      // write x0 dropped
      idle(); bus.wb_valid = 1; bus.wb_reg_we = 1; bus.wb_rd_addr = 0;
      bus.wb_alu_data = 32'h0000_DEAD; bus.wb_pc = 32'h0000_1020; bus.rs1_addr = 0; #1;
      chk("x0_bypass", bus.rs1_data, 32'h0);
      tick(); idle(); #1;
      chk("x0_stored", bus.rs1_data, 32'h0);

      // write x7 with same-cycle bypass
      idle(); bus.wb_valid = 1; bus.wb_reg_we = 1; bus.wb_rd_addr = 7;
      bus.wb_alu_data = 32'h0000_1234; bus.wb_pc = 32'h0000_1024; bus.rs1_addr = 7;
      bus.rs2_addr = 7; #1;
      chk("x7_bypass1", bus.rs1_data, 32'h0000_1234);
      chk("x7_bypass2", bus.rs2_data, 32'h0000_1234);
      tick(); idle(); #1;
      chk("x7_stored", bus.rs1_data, 32'h0000_1234);
      chk("retire_x7", bus.retire_pc, 32'h0000_1024);

      // stall: no arch update except mcycle
      idle(); bus.wb_valid = 1; bus.wb_stall = 1; bus.wb_reg_we = 1; bus.wb_rd_addr = 7;
      bus.wb_alu_data = 32'h0000_5555; bus.wb_pc = 32'h0000_0777;
      bus.wb_csr_we = 1; bus.wb_csr_addr = 12'h341; bus.wb_csr_wdata = 32'h0000_0040;
      bus.csr_raddr = 12'hB00; #1 m0 = bus.csr_rdata;
      bus.csr_raddr = 12'hB02; #1 i0 = bus.csr_rdata;
      rp0 = bus.retire_pc;
      chk("stall_nobyp", bus.rs1_data, 32'h0000_1234);
      bus.csr_raddr = 12'h341; #1 chk("stall_csrnobyp", bus.csr_rdata, 32'h0);
      @(posedge clk); #1;
      chk("stall_x7", bus.rs1_data, 32'h0000_1234);
      chk("stall_pc", bus.retire_pc, rp0);
      chk("stall_mepc", bus.csr_rdata, 32'h0);
      bus.csr_raddr = 12'hB02; #1 chk("stall_minstret", bus.csr_rdata, i0);
      bus.csr_raddr = 12'hB00; #1 chk("stall_mcycle", bus.csr_rdata, m0 + 32'd1);

      // one plain commit bumps minstret by exactly one
      idle(); bus.wb_valid = 1; bus.wb_pc = 32'h0000_0030;
      bus.csr_raddr = 12'hB02; #1 i1 = bus.csr_rdata;
      tick(); idle(); #1;
      chk("minstret_inc", bus.csr_rdata, i1 + 32'd1);

      // minstret low carry into high
      csr_wr(12'hB02, 32'hFFFF_FFFF); tick(); idle(); #1;
      chk("minstret_lo_wr", bus.csr_rdata, 32'hFFFF_FFFF);
      bus.csr_raddr = 12'hB82; #1 chk("minstret_hi_keep", bus.csr_rdata, 32'h0);
      idle(); bus.wb_valid = 1; bus.wb_pc = 32'h0000_0034; tick(); idle(); #1;
      chk("minstret_hi_carry", bus.csr_rdata, 32'h1);
      bus.csr_raddr = 12'hB02; #1 chk("minstret_lo_wrap", bus.csr_rdata, 32'h0);

      // mcycle to 2^64-1 then wrap to 0
      csr_wr(12'hB80, 32'hFFFF_FFFF); tick();
      csr_wr(12'hB00, 32'hFFFF_FFFF); tick(); idle();
      bus.csr_raddr = 12'hB00; #1 chk("mcycle_lo_max", bus.csr_rdata, 32'hFFFF_FFFF);
      bus.csr_raddr = 12'hB80; #1 chk("mcycle_hi_max", bus.csr_rdata, 32'hFFFF_FFFF);
      tick();
      chk("mcycle_hi_wrap", bus.csr_rdata, 32'h0);
      bus.csr_raddr = 12'hB00; #1 chk("mcycle_lo_wrap", bus.csr_rdata, 32'h0);

      // mtvec alignment, bypass and unmapped CSR
      csr_wr(12'h305, 32'h8000_0003); bus.csr_raddr = 12'h305; #1;
      chk("mtvec_bypass", bus.csr_rdata, 32'h8000_0000);
      tick(); idle(); #1;
      chk("mtvec_stored", bus.csr_rdata, 32'h8000_0000);
      csr_wr(12'h7C0, 32'h1234_5678); bus.csr_raddr = 12'h7C0; #1;
      chk("unmapped_bypass", bus.csr_rdata, 32'h0);
      tick(); idle(); #1;
      chk("unmapped_read", bus.csr_rdata, 32'h0);
      bus.csr_raddr = 12'h305; #1 chk("mtvec_intact", bus.csr_rdata, 32'h8000_0000);
      csr_wr(12'h342, 32'h8000_000B); tick(); idle(); bus.csr_raddr = 12'h342; #1;
      chk("mcause", bus.csr_rdata, 32'h8000_000B);

      // async reset mid-operation, in-flight write lost
      idle(); bus.wb_valid = 1; bus.wb_reg_we = 1; bus.wb_rd_addr = 9;
      bus.wb_alu_data = 32'h0000_9999; bus.wb_pc = 32'h0000_0990;
      bus.rs1_addr = 5; bus.rs2_addr = 9; bus.csr_raddr = 12'h305;
      #2 rst = 1; #1;
      chk("arst_x5", bus.rs1_data, 32'h0);
      chk("arst_pc", bus.retire_pc, RPC);
      chk("arst_mtvec", bus.csr_rdata, MTVR);
      idle(); tick(); rst = 0; #1;
      chk("arst_x9", bus.rs2_data, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
